// File: rtl/ndro_pkg.sv
// Shared types and defaults for the NDRO pulse sequencer and its benches.
// Holds the command encoding, FSM states and the counter sizing helper.
package ndro_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_SET   = 2'b01,
        OP_RESET = 2'b10,
        OP_READ  = 2'b11
    } ndro_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PULSE   = 2'b01,
        ST_WAIT_RD = 2'b10,
        ST_GUARD   = 2'b11
    } ndro_state_e;

    localparam int unsigned NDRO_GUARD_CYCLES = 2;
    localparam int unsigned NDRO_READ_LAT     = 1;
    localparam int unsigned NDRO_CNT_W        = 8;

    // Bits needed to hold the largest reload value (max(a, b) - 1), at least 1.
    function automatic int unsigned ndro_cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/ndro_delay_counter.sv
// Loadable down-counter with a registered done flag; done is high whenever
// the count is zero, so a load of N-1 yields done in the Nth cycle after loading.
module ndro_delay_counter #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            done  <= 1'b1;
        end else if (load) begin
            count <= load_val;
            done  <= (load_val == '0);
        end else if (count != '0) begin
            count <= count - W'(1);
            done  <= (count == W'(1));
        end
    end

endmodule

// File: rtl/ndro_pulse_sequencer.sv
// Command-driven set/reset/read pulse sequencer for basic_ndro with an idle
// guard between pulses and a shadow model of the stored bit for read-back checks.
module ndro_pulse_sequencer
    import ndro_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES = NDRO_GUARD_CYCLES,
    parameter int unsigned READ_LAT     = NDRO_READ_LAT,
    parameter int unsigned CNT_W        = NDRO_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    output logic             ndro_set,
    output logic             ndro_reset,
    output logic             ndro_clk,
    input  logic             ndro_out,
    output logic             rd_valid,
    output logic             rd_data,
    output logic             rd_mismatch,
    output logic             model_bit,
    output logic [CNT_W-1:0] err_cnt
);

    localparam bit          HAS_GUARD = (GUARD_CYCLES != 0);
    localparam int unsigned DW        = ndro_cnt_width(READ_LAT, GUARD_CYCLES);
    localparam int unsigned RD_LOAD   = READ_LAT - 1;
    localparam int unsigned GD_LOAD   = HAS_GUARD ? GUARD_CYCLES - 1 : 0;

    ndro_state_e   state;
    ndro_op_e      op_q;
    logic          cnt_load_c;
    logic [DW-1:0] cnt_val_c;
    logic          cnt_done;
    logic          rd_miss_c;

    assign cmd_ready = (state == ST_IDLE);
    assign rd_miss_c = ndro_out ^ model_bit;

    // Counter reload on entry to WAIT_RD or GUARD.
    always_comb begin
        cnt_load_c = 1'b0;
        cnt_val_c  = DW'(GD_LOAD);
        case (state)
            ST_PULSE: begin
                if (op_q == OP_READ) begin
                    cnt_load_c = 1'b1;
                    cnt_val_c  = DW'(RD_LOAD);
                end else begin
                    cnt_load_c = HAS_GUARD;
                end
            end
            ST_WAIT_RD: cnt_load_c = cnt_done && HAS_GUARD;
            default:    cnt_load_c = 1'b0;
        endcase
    end

    ndro_delay_counter #(
        .W (DW)
    ) u_delay (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load_c),
        .load_val (cnt_val_c),
        .done     (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            op_q        <= OP_NOP;
            ndro_set    <= 1'b0;
            ndro_reset  <= 1'b0;
            ndro_clk    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= 1'b0;
            rd_mismatch <= 1'b0;
            model_bit   <= 1'b0;
            err_cnt     <= '0;
        end else begin
            ndro_set    <= 1'b0;
            ndro_reset  <= 1'b0;
            ndro_clk    <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= 1'b0;
            rd_mismatch <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // NOP is consumed here without touching the NDRO or the guard.
                    if (cmd_valid && (ndro_op_e'(cmd_op) != OP_NOP)) begin
                        op_q       <= ndro_op_e'(cmd_op);
                        state      <= ST_PULSE;
                        ndro_set   <= (ndro_op_e'(cmd_op) == OP_SET);
                        ndro_reset <= (ndro_op_e'(cmd_op) == OP_RESET);
                        ndro_clk   <= (ndro_op_e'(cmd_op) == OP_READ);
                    end
                end
                ST_PULSE: begin
                    case (op_q)
                        OP_SET:   model_bit <= 1'b1;
                        OP_RESET: model_bit <= 1'b0;
                        default:  model_bit <= model_bit;
                    endcase
                    if (op_q == OP_READ) begin
                        state <= ST_WAIT_RD;
                    end else begin
                        state <= HAS_GUARD ? ST_GUARD : ST_IDLE;
                    end
                end
                ST_WAIT_RD: begin
                    if (cnt_done) begin
                        rd_valid    <= 1'b1;
                        rd_data     <= ndro_out;
                        rd_mismatch <= rd_miss_c;
                        if (rd_miss_c && (err_cnt != '1)) begin
                            err_cnt <= err_cnt + CNT_W'(1);
                        end
                        state <= HAS_GUARD ? ST_GUARD : ST_IDLE;
                    end
                end
                ST_GUARD: begin
                    if (cnt_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ndro_pulse_sequencer.sv
// Randomized bench for ndro_pulse_sequencer against a cycle-scheduled
// reference model of command acceptance, pulse timing and read-back results.
module tb_ndro_pulse_sequencer;
    import ndro_pkg::*;

    localparam int unsigned G  = NDRO_GUARD_CYCLES;
    localparam int unsigned RL = NDRO_READ_LAT;
    localparam int unsigned CW = NDRO_CNT_W;
    localparam int          ERR_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic [1:0]    cmd_op;
    logic          cmd_ready;
    logic          ndro_set;
    logic          ndro_reset;
    logic          ndro_clk;
    logic          ndro_out;
    logic          rd_valid;
    logic          rd_data;
    logic          rd_mismatch;
    logic          model_bit;
    logic [CW-1:0] err_cnt;

    always #5 clk = ~clk;

    ndro_pulse_sequencer #(
        .GUARD_CYCLES (G),
        .READ_LAT     (RL),
        .CNT_W        (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_ready   (cmd_ready),
        .ndro_set    (ndro_set),
        .ndro_reset  (ndro_reset),
        .ndro_clk    (ndro_clk),
        .ndro_out    (ndro_out),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_mismatch (rd_mismatch),
        .model_bit   (model_bit),
        .err_cnt     (err_cnt)
    );

    typedef struct packed {
        logic d;
        logic m;
    } rd_t;

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    // Reference model: events scheduled by the cycle in which they must appear.
    int  idle_from;
    int  exp_pulse[int];
    rd_t exp_rd[int];
    bit  mb_exp;
    int  mb_pend_cyc;
    bit  mb_pend_val;
    bit  phys_exp;
    bit  real_bit;
    bit  force_en;
    bit  force_val;
    int  err_exp;
    int  last_pulse_cyc;
    int  last_pulse_min;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        idle_from   = cyc + 1;
        exp_pulse.delete();
        exp_rd.delete();
        mb_exp      = 1'b0;
        mb_pend_cyc = -1;
        err_exp     = 0;
        last_pulse_cyc = -1;
    endtask

    task automatic check_cycle();
        int       ep;
        bit [2:0] ev;
        rd_t      r;
        if (mb_pend_cyc == cyc) mb_exp = mb_pend_val;
        check("cmd_ready", cmd_ready, cyc >= idle_from);
        ep = exp_pulse.exists(cyc) ? exp_pulse[cyc] : int'(OP_NOP);
        ev = {ep == int'(OP_READ), ep == int'(OP_RESET), ep == int'(OP_SET)};
        check("pulses", {ndro_clk, ndro_reset, ndro_set}, ev);
        check("pulse_onehot", $countones({ndro_clk, ndro_reset, ndro_set}) <= 1, 1);
        if (ndro_clk || ndro_reset || ndro_set) begin
            if (last_pulse_cyc >= 0)
                check("pulse_gap", (cyc - last_pulse_cyc) >= last_pulse_min, 1);
            last_pulse_cyc = cyc;
            last_pulse_min = ndro_clk ? int'(RL + G + 2) : int'(G + 2);
        end
        if (exp_rd.exists(cyc)) begin
            r = exp_rd[cyc];
            if (r.m && err_exp < ERR_MAX) err_exp++;
            check("rd_valid", rd_valid, 1);
            check("rd_data", rd_data, r.d);
            check("rd_mismatch", rd_mismatch, r.m);
        end else begin
            check("rd_valid_idle", rd_valid, 0);
        end
        check("model_bit", model_bit, mb_exp);
        check("err_cnt", err_cnt, err_exp);
    endtask

    // One cycle: check outputs, drive inputs, predict acceptance, advance.
    task automatic step(input bit rst, input bit v, input ndro_op_e op, output bit acc);
        rd_t r;
        check_cycle();
        if (ndro_set)   real_bit = 1'b1;
        if (ndro_reset) real_bit = 1'b0;
        ndro_out  = force_en ? force_val : real_bit;
        reset     = rst;
        cmd_valid = v;
        cmd_op    = op;
        acc       = 1'b0;
        if (rst) begin
            model_reset();
        end else if (v && cyc >= idle_from) begin
            acc = 1'b1;
            case (op)
                OP_SET, OP_RESET: begin
                    exp_pulse[cyc + 1] = int'(op);
                    mb_pend_cyc = cyc + 2;
                    mb_pend_val = (op == OP_SET);
                    phys_exp    = (op == OP_SET);
                    idle_from   = cyc + 2 + int'(G);
                end
                OP_READ: begin
                    exp_pulse[cyc + 1] = int'(op);
                    r.d = force_en ? force_val : phys_exp;
                    r.m = r.d ^ mb_exp;
                    exp_rd[cyc + 2 + int'(RL)] = r;
                    idle_from = cyc + 2 + int'(RL) + int'(G);
                end
                default: ;
            endcase
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, OP_NOP, a);
    endtask

    task automatic issue(input ndro_op_e op);
        bit a;
        int budget;
        a = 1'b0;
        budget = 50;
        while (!a && budget > 0) begin
            step(1'b0, 1'b1, op, a);
            budget--;
        end
        if (!a) check("accept_timeout", 0, 1);
    endtask

    initial begin
        bit       a;
        bit       hold_v;
        ndro_op_e hold_op;
        ndro_op_e alt;

        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'b00;
        ndro_out = 1'b0;
        force_en = 1'b0;
        force_val = 1'b0;
        real_bit = 1'b0;
        phys_exp = 1'b0;
        last_pulse_min = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cyc = 0;
        model_reset();
        idle_from = 0;

        // SET at cycle 0, then a clean read-back of 1.
        issue(OP_SET);
        idle(5);
        issue(OP_READ);
        idle(5);

        // RESET then forced-high read: mismatch, then drive the counter to saturation.
        issue(OP_RESET);
        idle(4);
        force_en = 1'b1;
        force_val = 1'b1;
        issue(OP_READ);
        idle(5);
        repeat (300) issue(OP_READ);
        idle(6);
        check("err_saturated", err_cnt, ERR_MAX);
        force_en = 1'b0;

        // Reset while the read is waiting on its sample.
        issue(OP_SET);
        idle(5);
        issue(OP_READ);
        step(1'b0, 1'b0, OP_NOP, a);
        step(1'b1, 1'b0, OP_NOP, a);
        idle(6);

        // Continuous NOP offers.
        repeat (50) step(1'b0, 1'b1, OP_NOP, a);

        // Valid held high with ops rotating on each acceptance.
        alt = OP_SET;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 1'b1, alt, a);
            if (a) alt = (alt == OP_READ) ? OP_SET : ndro_op_e'(2'(alt + 2'd1));
        end
        idle(8);

        // Random traffic with occasional forcing and resets.
        hold_v = 1'b0;
        hold_op = OP_NOP;
        for (int i = 0; i < 3000; i++) begin
            if (!hold_v) begin
                if (cyc >= idle_from && $urandom_range(0, 19) == 0) begin
                    force_en  = $urandom_range(0, 1) == 1;
                    force_val = $urandom_range(0, 1) == 1;
                end
                hold_v  = $urandom_range(0, 9) < 7;
                hold_op = ndro_op_e'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 149) == 0) begin
                step(1'b1, hold_v, hold_op, a);
                hold_v = 1'b0;
            end else begin
                step(1'b0, hold_v, hold_op, a);
                if (a) hold_v = 1'b0;
            end
        end
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
